// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^163) reduction datapath.
package gf2m_pkg;

  localparam int M      = 163;
  localparam int PROD_W = 2 * M - 1;
  // Wide enough to address every product bit (0..324).
  localparam int IDX_W  = 9;

  localparam logic [M-1:0] SECT163_POLY = 163'hC9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Counter width for a count range of 0..n-1. It never drops to zero bits,
  // even when a single REDUCE cycle is enough.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gf2m_reduce_step.sv
// One conditional shift-XOR reduction step at a runtime bit index.
// If r_in[idx] is set, {1,poly} is XORed in, aligned so that its x^163 term
// lands on bit idx. That clears bit idx and folds the result into bits
// idx-1..idx-163. The XOR is always computed and is only masked by the
// data bit. The logic depth and timing therefore do not depend on the data.
module gf2m_reduce_step
  import gf2m_pkg::*;
(
  input  logic [PROD_W-1:0] r_in,
  input  logic [M-1:0]      poly,
  input  logic [IDX_W-1:0]  idx,
  output logic [PROD_W-1:0] r_out
);

  logic [PROD_W-1:0] poly_full;
  logic [IDX_W-1:0]  shamt;
  logic [PROD_W-1:0] shifted;

  // Align the full polynomial under bit idx, then apply it when that bit is set.
  always_comb begin
    poly_full = {{(PROD_W-M-1){1'b0}}, 1'b1, poly};
    shamt     = idx - IDX_W'(M);
    shifted   = poly_full << shamt;
    r_out     = r_in ^ (shifted & {PROD_W{r_in[idx]}});
  end

endmodule

// File: rtl/gf2m_reducer.sv
// Digit-serial constant-time reduction of a 325-bit carry-less product
// modulo x^163 + poly. Each REDUCE cycle eliminates DIGIT product bits.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | in_ready=1, waiting for an operand
// ST_REDUCE | N = 162/DIGIT cycles, DIGIT chained steps per cycle
// ST_DONE   | out_valid=1, c holds the result until out_ready
module gf2m_reducer
  import gf2m_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  input  logic [M-1:0]      poly,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [M-1:0]      c
);

  localparam int N     = 162 / DIGIT;
  localparam int CNT_W = cnt_width(N);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(PROD_W - 1);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(DIGIT);

  generate
    if ((DIGIT < 1) || ((162 % DIGIT) != 0)) begin : g_bad_digit
      $error("gf2m_reducer: DIGIT=%0d must divide 162", DIGIT);
    end
  endgenerate

  state_t            state_q, state_d;
  logic [PROD_W-1:0] r_q;
  logic [M-1:0]      preg_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [M-1:0]      c_q;
  logic [PROD_W-1:0] r_reduced;
  logic              accept;
  logic              last_cycle;

  // Chain of DIGIT reduction steps. Each step sees the residue left by the
  // previous one. Every generate block keeps its own wires, so that the chain
  // is not one self-referencing array.
  genvar k;
  generate
    for (k = 0; k < DIGIT; k++) begin : g_step
      logic [PROD_W-1:0] r_cur;
      logic [PROD_W-1:0] r_next;
      logic [IDX_W-1:0]  step_idx;

      if (k == 0) begin : g_first
        assign r_cur = r_q;
      end else begin : g_link
        assign r_cur = g_step[k-1].r_next;
      end

      assign step_idx = idx_q - IDX_W'(k);

      gf2m_reduce_step u_step (
        .r_in  (r_cur),
        .poly  (preg_q),
        .idx   (step_idx),
        .r_out (r_next)
      );
    end
  endgenerate

  assign r_reduced  = g_step[DIGIT-1].r_next;
  assign accept     = in_valid && (state_q == ST_IDLE);
  assign last_cycle = (state_q == ST_REDUCE) && (cnt_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand capture, the residue update on each REDUCE cycle, and the
  // terminal-count down-counter that ends REDUCE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      preg_q <= '0;
      idx_q  <= IDX_TOP;
      cnt_q  <= '0;
    end else if (accept) begin
      r_q    <= prod;
      preg_q <= poly;
      idx_q  <= IDX_TOP;
      cnt_q  <= CNT_LOAD;
    end else if (state_q == ST_REDUCE) begin
      r_q   <= r_reduced;
      idx_q <= idx_q - IDX_STEP;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  // The result register loads on the last REDUCE edge and holds its value
  // afterwards. It therefore still shows the last result while in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
    end else if (last_cycle) begin
      c_q <= r_reduced[M-1:0];
    end
  end

  assign c = c_q;

endmodule

// File: tb/tb_gf2m_reducer.sv
// Directed and random bench for gf2m_reducer. DIGIT = 1, 2, 9 and 162 each get an instance.
module tb_gf2m_reducer;
  import gf2m_pkg::*;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              in_valid_a  [NI];
  logic              in_ready_a  [NI];
  logic              out_valid_a [NI];
  logic              out_ready_a [NI];
  logic [PROD_W-1:0] prod_a      [NI];
  logic [M-1:0]      poly_a      [NI];
  logic [M-1:0]      c_a         [NI];

  int errors = 0;
  int checks = 0;

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 9 : 162;
      gf2m_reducer #(.DIGIT(D)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_a[g]),
        .in_ready  (in_ready_a[g]),
        .prod      (prod_a[g]),
        .poly      (poly_a[g]),
        .out_valid (out_valid_a[g]),
        .out_ready (out_ready_a[g]),
        .c         (c_a[g])
      );
    end
  endgenerate

  function automatic int n_of(input int d);
    case (d)
      0:       return 162;
      1:       return 81;
      2:       return 18;
      default: return 1;
    endcase
  endfunction

  function automatic logic [M-1:0] rand163();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w[M-1:0];
  endfunction

  // Carry-less 163x163 product.
  function automatic logic [PROD_W-1:0] clmul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] sh;
    acc = '0;
    sh  = PROD_W'(a);
    for (int j = 0; j < M; j++) begin
      if (b[j]) acc ^= sh;
      sh = sh << 1;
    end
    return acc;
  endfunction

  // Field multiply by Horner's rule, reducing after every doubling.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b,
                                         input logic [M-1:0] p);
    logic [M-1:0] r;
    logic         msb;
    r = '0;
    for (int j = M - 1; j >= 0; j--) begin
      msb = r[M-1];
      r   = r << 1;
      if (msb) r ^= p;
      if (b[j]) r ^= a;
    end
    return r;
  endfunction

  // Drives one operand through instance d. It returns the result, the latency
  // counted from the accept edge, and the flags seen one cycle after the output handshake.
  task automatic do_op(input int d, input logic [PROD_W-1:0] p, input logic [M-1:0] q,
                       output logic [M-1:0] c_obs, output int lat,
                       output logic ov_after, output logic ir_after);
    logic [191:0] junk;
    prod_a[d]     = p;
    poly_a[d]     = q;
    in_valid_a[d] = 1'b1;
    @(negedge clk);
    in_valid_a[d] = 1'b0;
    junk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    prod_a[d] = {junk, junk[132:0]};
    poly_a[d] = junk[M-1:0];
    lat = 0;
    while (!out_valid_a[d] && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid_a[d]) lat = -1;
    c_obs = c_a[d];
    out_ready_a[d] = 1'b1;
    @(negedge clk);
    out_ready_a[d] = 1'b0;
    ov_after = out_valid_a[d];
    ir_after = in_ready_a[d];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < NI; d++) begin
      in_valid_a[d]  = 1'b0;
      out_ready_a[d] = 1'b0;
      prod_a[d]      = '0;
      poly_a[d]      = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NI; d++) begin
      checks++;
      if (in_ready_a[d] !== 1'b1)
        $display("FAIL reset_in_ready inst=%0d got=%b exp=1", d, in_ready_a[d]);
      if (in_ready_a[d] !== 1'b1) errors++;
      checks++;
      if (out_valid_a[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_valid inst=%0d got=%b exp=0", d, out_valid_a[d]);
      end
      checks++;
      if (c_a[d] !== '0) begin
        errors++;
        $display("FAIL reset_c inst=%0d got=%h exp=0", d, c_a[d]);
      end
    end
  endtask

  task automatic test_known_vectors();
    logic [PROD_W-1:0] p_tab [5];
    logic [M-1:0]      q_tab [5];
    logic [M-1:0]      e_tab [5];
    logic [M-1:0]      c_obs;
    int                lat;
    logic              ov_after, ir_after;
    p_tab[0] = '0;                 q_tab[0] = SECT163_POLY; e_tab[0] = '0;
    p_tab[1] = '0; p_tab[1][163] = 1'b1;
                                   q_tab[1] = SECT163_POLY; e_tab[1] = 163'hC9;
    p_tab[2] = '0; p_tab[2][164] = 1'b1;
                                   q_tab[2] = SECT163_POLY; e_tab[2] = 163'h192;
    p_tab[3] = 325'h1234;          q_tab[3] = SECT163_POLY; e_tab[3] = 163'h1234;
    p_tab[4] = '0; p_tab[4][163] = 1'b1; p_tab[4][3] = 1'b1;
                                   q_tab[4] = 163'h5;       e_tab[4] = 163'hD;
    for (int d = 0; d < NI; d++) begin
      for (int v = 0; v < 5; v++) begin
        do_op(d, p_tab[v], q_tab[v], c_obs, lat, ov_after, ir_after);
        checks++;
        if (c_obs !== e_tab[v]) begin
          errors++;
          $display("FAIL known_c inst=%0d vec=%0d got=%h exp=%h", d, v, c_obs, e_tab[v]);
        end
        checks++;
        if (lat !== n_of(d)) begin
          errors++;
          $display("FAIL known_latency inst=%0d vec=%0d got=%0d exp=%0d", d, v, lat, n_of(d));
        end
        checks++;
        if (ov_after !== 1'b0 || ir_after !== 1'b1) begin
          errors++;
          $display("FAIL known_handshake inst=%0d vec=%0d out_valid=%b in_ready=%b exp 0/1",
                   d, v, ov_after, ir_after);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [PROD_W-1:0] p;
    logic [M-1:0]      c_hold;
    int                waitc;
    p = '0;
    p[164] = 1'b1;
    prod_a[1] = p;
    poly_a[1] = SECT163_POLY;
    in_valid_a[1] = 1'b1;
    @(negedge clk);
    in_valid_a[1] = 1'b0;
    waitc = 0;
    while (!out_valid_a[1] && waitc < 400) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (waitc !== 81) begin
      errors++;
      $display("FAIL bp_latency got=%0d exp=81", waitc);
    end
    c_hold = c_a[1];
    checks++;
    if (c_hold !== 163'h192) begin
      errors++;
      $display("FAIL bp_c got=%h exp=192", c_hold);
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        in_valid_a[1] = 1'b1;
        prod_a[1] = p >> 1;
      end
      if (k == 4) in_valid_a[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid_a[1] !== 1'b1 || c_a[1] !== 163'h192 || in_ready_a[1] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d out_valid=%b c=%h in_ready=%b exp 1/192/0",
                 k, out_valid_a[1], c_a[1], in_ready_a[1]);
      end
    end
    out_ready_a[1] = 1'b1;
    @(negedge clk);
    out_ready_a[1] = 1'b0;
    checks++;
    if (out_valid_a[1] !== 1'b0 || in_ready_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release out_valid=%b in_ready=%b exp 0/1", out_valid_a[1], in_ready_a[1]);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid_a[1] !== 1'b0 || in_ready_a[1] !== 1'b1 || c_a[1] !== 163'h192) begin
      errors++;
      $display("FAIL bp_pulse_ignored out_valid=%b in_ready=%b c=%h exp 0/1/192",
               out_valid_a[1], in_ready_a[1], c_a[1]);
    end
  endtask

  task automatic test_reset_abort();
    logic [PROD_W-1:0] p;
    logic [M-1:0]      c_obs;
    int                lat;
    logic              ov_after, ir_after;
    p = '0;
    p[164] = 1'b1;
    prod_a[1] = p;
    poly_a[1] = SECT163_POLY;
    in_valid_a[1] = 1'b1;
    @(negedge clk);
    in_valid_a[1] = 1'b0;
    repeat (39) @(negedge clk);
    checks++;
    if (in_ready_a[1] !== 1'b0 || out_valid_a[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_reduce in_ready=%b out_valid=%b exp 0/0", in_ready_a[1], out_valid_a[1]);
    end
    rst = 1'b1;
    in_valid_a[1] = 1'b1;
    prod_a[1] = p >> 1;
    @(negedge clk);
    rst = 1'b0;
    in_valid_a[1] = 1'b0;
    checks++;
    if (in_ready_a[1] !== 1'b1 || out_valid_a[1] !== 1'b0 || c_a[1] !== '0) begin
      errors++;
      $display("FAIL abort_after_rst in_ready=%b out_valid=%b c=%h exp 1/0/0",
               in_ready_a[1], out_valid_a[1], c_a[1]);
    end
    @(negedge clk);
    checks++;
    if (in_ready_a[1] !== 1'b1 || out_valid_a[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst_with_valid in_ready=%b out_valid=%b exp 1/0", in_ready_a[1], out_valid_a[1]);
    end
    do_op(1, p >> 1, SECT163_POLY, c_obs, lat, ov_after, ir_after);
    checks++;
    if (c_obs !== 163'hC9) begin
      errors++;
      $display("FAIL abort_next_c got=%h exp=c9", c_obs);
    end
    checks++;
    if (lat !== 81) begin
      errors++;
      $display("FAIL abort_next_latency got=%0d exp=81", lat);
    end
  endtask

  task automatic test_random(input int d, input int nvec);
    logic [M-1:0] a, b, e, c_obs;
    int           lat;
    logic         ov_after, ir_after;
    for (int v = 0; v < nvec; v++) begin
      a = rand163();
      b = rand163();
      e = gf_mul(a, b, SECT163_POLY);
      do_op(d, clmul(a, b), SECT163_POLY, c_obs, lat, ov_after, ir_after);
      checks++;
      if (c_obs !== e) begin
        errors++;
        $display("FAIL rand_c inst=%0d vec=%0d got=%h exp=%h", d, v, c_obs, e);
      end
      checks++;
      if (lat !== n_of(d)) begin
        errors++;
        $display("FAIL rand_latency inst=%0d vec=%0d got=%0d exp=%0d", d, v, lat, n_of(d));
      end
      checks++;
      if (ov_after !== 1'b0 || ir_after !== 1'b1) begin
        errors++;
        $display("FAIL rand_handshake inst=%0d vec=%0d out_valid=%b in_ready=%b exp 0/1",
                 d, v, ov_after, ir_after);
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_reset_abort();
    fork
      test_random(0, 250);
      test_random(1, 250);
      test_random(2, 250);
      test_random(3, 250);
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gf2m_reducer.md
# gf2m_reducer

Sequential modular-reduction stage for the GF(2^163) datapath. It sits directly downstream of the 163×163 carry-less (Karatsuba) multiplier. It accepts the unreduced 325-bit polynomial product and a reduction polynomial, and returns the 163-bit field element (product mod P). Reduction is digit-serial with a fixed, data-independent cycle count (constant-time), and the block is flow-controlled by valid/ready on both sides.

## Interface
- `DIGIT`, default 2: product bits eliminated per cycle. Legal values are divisors of 162 (1, 2, 3, 6, 9, 18, 27, 54, 81, 162). Any other value is an elaboration error.
- `clk`  input  1  clock. All state updates occur on the rising edge.
- `rst`  input  1  reset. One clock; reset is synchronous and active-high.
- `in_valid`  input  1  `prod`/`poly` valid.
- `in_ready`  output  1  block can accept an operand.
- `prod`  input  325  unreduced product; bit i is the coefficient of x^i.
- `poly`  input  163  low coefficients of P. The x^163 term is implicit; e.g. sect163 is 163'hC9.
- `out_valid`  output  1  `c` holds a finished result.
- `out_ready`  input  1  downstream accepts `c`.
- `c`  output  163  reduced result, degree < 163.

## Operation
- FSM states: IDLE, REDUCE, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: latch `prod` into R[324:0] and `poly` into Preg, set index i=324, go to REDUCE.
- **REDUCE**
  - Each cycle performs DIGIT chained single-bit steps.
  - Each step: if R[i]=1 then R ^= ({1'b1,Preg} << (i-163)); then i = i-1.
  - Each step clears bit i and may modify bits i-1 down to i-163. The next step in the same cycle sees the updated R.
  - The XOR is applied or masked by R[i]; the step count and timing never depend on data. There is no early exit when the upper bits are already zero.
  - After N = 162/DIGIT cycles, i=162 and R[324:163]=0. Go to DONE.
- **DONE**
  - `out_valid`=1 and `c`=R[162:0].
  - On `out_ready`: go to IDLE.
- All arithmetic is GF(2): XOR only, no carries.
- `prod` with degree < 163 passes through unchanged after N cycles.
- Operands are captured only on the accept edge. Changes to `prod`/`poly` afterwards have no effect.
- `in_ready` = (state==IDLE) exactly.
  - No accept occurs in REDUCE or DONE; `in_valid` is ignored there.
  - There is no same-cycle output-handshake/input-accept overlap.
- `c` is registered and holds its value outside DONE (last result, or 0 after reset). It is meaningful only while `out_valid`=1.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `c`=0, R=0, Preg=0, i=324.
- Latency: accept at edge t gives `out_valid`=1 from the cycle after edge t+N. Default DIGIT=2 gives N=81.
- Throughput: one result per N+2 cycles at best (accept edge, N REDUCE edges, output handshake edge).
- `out_valid`, once high, stays high with `c` stable until the `out_ready` edge. It drops in the following cycle.
- `rst` dominates in any state. It takes effect on the next edge, aborts any in-flight reduction, and no `out_valid` is produced for the aborted operand.
- `rst` asserted together with `in_valid`: the operand is not accepted.

## Structure
- Shared package `gf2m_pkg`:
  - M=163, PROD_W=2*M-1=325.
  - Constant `SECT163_POLY`=163'hC9.
  - FSM state enum.
- Sub-module `gf2m_reduce_step`: combinational, one conditional shift-XOR at a given index.
  - DIGIT instances are chained inside the REDUCE datapath.
  - The step index is a runtime input: base i minus the step offset.
- The counter width covers 0..N-1; the FSM and counter live in the top module.

## Test plan
- `prod`=0, `poly`=163'hC9 → `c`=0 exactly N cycles after accept.
- `prod`=1<<163, `poly`=163'hC9 → `c`=163'hC9.
- `prod`=1<<164, `poly`=163'hC9 → `c`=163'h192. Also `prod`=325'h1234 → `c`=163'h1234 (pass-through).
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`.
  - `c` and `out_valid` stay stable and `in_ready`=0.
  - A pulsed `in_valid` is ignored.
  - Release → IDLE the next cycle.
- Assert `rst` at REDUCE cycle 40 → the next cycle shows `in_ready`=1, `out_valid`=0, `c`=0. A following operand (1<<163) reduces correctly with full latency N.
- Random test, ≥1000 vectors, DIGIT ∈ {1, 2, 9, 162}.
  - `prod` = carry-less product of random 163-bit A and B, with `poly`=163'hC9.
  - `c` must match a software GF(2^163) multiply-reduce model.
  - Latency is always exactly N, independent of data.
